// File: rtl/cla_multicycle_adder.sv
// Multi-cycle WIDTH-bit add/subtract built on one reused 16-bit two-level carry-lookahead slice.
// Define CLA_FLAGS_EN to build the registered OVF/ZERO flags; otherwise both ports are tied to 0.
module cla_multicycle_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic             CIN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             READY,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT,
   output logic             OVF,
   output logic             ZERO
);

   localparam int unsigned NSLICE = WIDTH / 16;
   localparam int unsigned IdxW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, cout_q, cout_d;
`ifdef CLA_FLAGS_EN
   logic             ovf_q, ovf_d, zero_q, zero_d;
`endif

   logic [15:0] sl_a, sl_b, p, g, s;
   logic [16:0] c;
   logic [3:0]  gp, gg;

   // Operand slice selected by the slice index
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IdxW'(i)) begin
            sl_a = a_q[16*i +: 16];
            sl_b = b_q[16*i +: 16];
         end
      end
      p = sl_a ^ sl_b;
      g = sl_a & sl_b;
   end

   // First-level 4-bit units: group propagate/generate
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         gp[j] = &p[4*j +: 4];
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
                 (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      end
   end

   // Second-level unit gives group carries; first-level units then resolve in-group carries
   always_comb begin
      c = '0;
      c[0]  = carry_q;
      c[4]  = gg[0] | (gp[0] & c[0]);
      c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
      c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
      c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]) |
              (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
      for (int j = 0; j < 4; j++) begin
         c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                    (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      end
      s = p ^ c[15:0];
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;
`ifdef CLA_FLAGS_EN
      ovf_d   = ovf_q;
      zero_d  = zero_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (START) begin
               a_d     = A;
               b_d     = B ^ {WIDTH{SUB}};
               carry_d = SUB | CIN;
               idx_d   = '0;
               state_d = StRun;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = StIdle;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         StRun: begin
            for (int i = 0; i < NSLICE; i++) begin
               if (idx_q == IdxW'(i)) sum_d[16*i +: 16] = s;
            end
            carry_d = c[16];
            idx_d   = idx_q + IdxW'(1);
            if (idx_q == LastIdx) begin
               state_d = StDone;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cout_d  = c[16];
`ifdef CLA_FLAGS_EN
               // c[15] here is the carry into the result MSB
               ovf_d   = c[15] ^ c[16];
               zero_d  = ~|sum_d;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
`ifdef CLA_FLAGS_EN
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
`ifdef CLA_FLAGS_EN
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
`endif
      end
   end

   assign READY = ready_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign SUM   = sum_q;
   assign COUT  = cout_q;
`ifdef CLA_FLAGS_EN
   assign OVF   = ovf_q;
   assign ZERO  = zero_q;
`else
   assign OVF   = 1'b0;
   assign ZERO  = 1'b0;
`endif

endmodule
